// File: rtl/instr_fetch_decode_pkg.sv
// Shared CPU constants for the fetch/decode front end: opcodes, conditions,
// operand types, ALU ops, instruction field positions and front-end states.
package instr_fetch_decode_pkg;

  // Instruction field positions within the 35-bit word (MSB of each field)
  localparam int OPC_MSB   = 34;
  localparam int SUB_MSB   = 30;
  localparam int SRC_T_MSB = 27;
  localparam int SRC_MSB   = 25;
  localparam int DST_T_MSB = 17;
  localparam int DST_MSB   = 15;
  localparam int ADR_MSB   = 7;

  localparam int FIELD_INSTR_W = 35;
  localparam int FIELD_ADDR_W  = 8;

  // Opcodes
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ATC = 4'h3;
  localparam logic [3:0] OP_ACC = 4'h4;

  // Jump conditions
  localparam logic [2:0] COND_UNC   = 3'd0;
  localparam logic [2:0] COND_ZERO  = 3'd1;
  localparam logic [2:0] COND_NZERO = 3'd2;
  localparam logic [2:0] COND_CARRY = 3'd3;
  localparam logic [2:0] COND_NEG   = 3'd4;

  // Operand types
  localparam logic [1:0] T_REG = 2'd0;
  localparam logic [1:0] T_NUM = 2'd1;

  // ALU operations
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  // Well-known register numbers
  localparam logic [7:0] REG_FLAG = 8'h10;
  localparam logic [7:0] REG_GOUT = 8'h11;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    ISSUE   = 2'd1,
    WAIT_BR = 2'd2
  } fd_state_e;

  // Redirect class of an accepted instruction
  typedef enum logic [1:0] {
    CLS_SEQ,
    CLS_JUMP,
    CLS_BRANCH
  } instr_class_e;

  function automatic instr_class_e classify(input logic [3:0] opcode, input logic [2:0] sub);
    instr_class_e cls;
    cls = CLS_SEQ;
    if (opcode == OP_JMP) begin
      cls = (sub == COND_UNC) ? CLS_JUMP : CLS_BRANCH;
    end else if (opcode == OP_ATC) begin
      cls = CLS_BRANCH;
    end
    return cls;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_field_split.sv
// Pure combinational slice of the instruction register into its decode fields.
module instr_field_split
  import instr_fetch_decode_pkg::*;
(
  input  logic [34:0] ir,
  output logic [3:0]  opcode,
  output logic [2:0]  sub,
  output logic [1:0]  src_t,
  output logic [7:0]  src,
  output logic [1:0]  dst_t,
  output logic [7:0]  dst,
  output logic [7:0]  addr
);

  assign opcode = ir[OPC_MSB   -: 4];
  assign sub    = ir[SUB_MSB   -: 3];
  assign src_t  = ir[SRC_T_MSB -: 2];
  assign src    = ir[SRC_MSB   -: 8];
  assign dst_t  = ir[DST_T_MSB -: 2];
  assign dst    = ir[DST_MSB   -: 8];
  assign addr   = ir[ADR_MSB   -: 8];

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: owns the PC, registers ROM words, issues decoded
// fields over valid/ready and resolves JMP/ATC redirection.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 35
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [3:0]         dec_opcode,
  output logic [2:0]         dec_sub,
  output logic [1:0]         dec_src_t,
  output logic [7:0]         dec_src,
  output logic [1:0]         dec_dst_t,
  output logic [7:0]         dec_dst,
  output logic [ADDR_W-1:0]  dec_addr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               br_valid,
  input  logic               br_taken
);

  fd_state_e          state, state_next;
  instr_class_e       cls;
  logic [ADDR_W-1:0]  pc, pc_next, pc_inc;
  logic [ADDR_W-1:0]  pc_fetched;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;
  logic [7:0]         addr_field;

  instr_field_split u_split (
    .ir     (ir),
    .opcode (dec_opcode),
    .sub    (dec_sub),
    .src_t  (dec_src_t),
    .src    (dec_src),
    .dst_t  (dec_dst_t),
    .dst    (dec_dst),
    .addr   (addr_field)
  );

  assign dec_addr  = ADDR_W'(addr_field);
  assign dec_pc    = pc_fetched;
  assign rom_addr  = pc;
  assign dec_valid = (state == ISSUE);

  // Wraps modulo 2^ADDR_W by truncation
  assign pc_inc = pc + ADDR_W'(1);
  assign cls    = classify(dec_opcode, dec_sub);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    unique case (state)
      FETCH: begin
        ir_load    = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (dec_ready) begin
          unique case (cls)
            CLS_JUMP: begin
              pc_next    = dec_addr;
              state_next = FETCH;
            end
            CLS_BRANCH: begin
              state_next = WAIT_BR;
            end
            default: begin
              pc_next    = pc_inc;
              state_next = FETCH;
            end
          endcase
        end
      end
      WAIT_BR: begin
        // The branch target comes from the held IR, not from a fresh fetch
        if (br_valid) begin
          pc_next    = br_taken ? dec_addr : pc_inc;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= '0;
      pc_fetched <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) begin
        ir         <= rom_data;
        pc_fetched <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: behavioural ROM, scoreboard of
// expected issues, a field table and hand-written redirect/reset sequences.
module tb_instr_fetch_decode;
  import instr_fetch_decode_pkg::*;

  localparam int AW = 8;
  localparam int IW = 35;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          dec_valid, dec_ready;
  logic [3:0]    dec_opcode;
  logic [2:0]    dec_sub;
  logic [1:0]    dec_src_t, dec_dst_t;
  logic [7:0]    dec_src, dec_dst;
  logic [AW-1:0] dec_addr, dec_pc;
  logic          br_valid, br_taken;

  logic [IW-1:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_opcode (dec_opcode),
    .dec_sub    (dec_sub),
    .dec_src_t  (dec_src_t),
    .dec_src    (dec_src),
    .dec_dst_t  (dec_dst_t),
    .dec_dst    (dec_dst),
    .dec_addr   (dec_addr),
    .dec_pc     (dec_pc),
    .br_valid   (br_valid),
    .br_taken   (br_taken)
  );

  // Expected issue: fetch address followed by the fields in word order
  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] opc;
    logic [2:0] sub;
    logic [1:0] st;
    logic [7:0] src;
    logic [1:0] dt;
    logic [7:0] dst;
    logic [7:0] adr;
  } exp_t;

  typedef struct {
    logic [IW-1:0] word;
    logic [3:0]    opc;
    logic [2:0]    sub;
    logic [1:0]    st;
    logic [7:0]    src;
    logic [1:0]    dt;
    logic [7:0]    dst;
    logic [7:0]    adr;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_count = 0;
  int   last_acc = -1;
  int   prev_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t dut_fields();
    return {dec_pc, dec_opcode, dec_sub, dec_src_t, dec_src, dec_dst_t, dec_dst, dec_addr};
  endfunction

  function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [2:0] s,
                                       input logic [1:0] st, input logic [7:0] src,
                                       input logic [1:0] dt, input logic [7:0] dst,
                                       input logic [7:0] a);
    return {o, s, st, src, dt, dst, a};
  endfunction

  // Expectation for the word currently stored at ROM address pc
  task automatic push_exp(input logic [7:0] pc);
    exp_t e;
    e = {pc, rom[pc]};
    sb.push_back(e);
  endtask

  // Handshake monitor: every acceptance must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
      exp_t e;
      acc_count++;
      prev_acc = last_acc;
      last_acc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: dec_pc=0x%0h with nothing expected", dec_pc);
      end else begin
        e = sb.pop_front();
        check("issue_pc", dec_pc, e.pc);
        check("issue_fields", dut_fields(), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    dec_ready = 1'b0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Run until every expected issue has been seen, then drop ready
  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d issues pending after %0d cycles", name, sb.size(), max_cyc);
      sb.delete();
    end
    dec_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    while (dec_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    if (dec_valid !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: dec_valid never rose within %0d cycles", name, max_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    exp_t e;
    int   base;

    dec_ready = 1'b0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    clear_rom();

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_addr_valid", {rom_addr, dec_valid}, 9'h0);
    check("reset_fields", dut_fields(), 43'h0);

    // Straight-line code: set(FLAG,128) ; mov(FLAG,GOUT)
    rom[0] = mk(OP_MOV, ALU_PASS, T_NUM, 8'd128, T_REG, REG_FLAG, 8'h00);
    rom[1] = mk(OP_MOV, ALU_PASS, T_REG, REG_FLAG, T_REG, REG_GOUT, 8'h00);
    do_reset();
    e = {8'd0, OP_MOV, ALU_PASS, T_NUM, 8'd128, T_REG, REG_FLAG, 8'h00};
    sb.push_back(e);
    e = {8'd1, OP_MOV, ALU_PASS, T_REG, REG_FLAG, T_REG, REG_GOUT, 8'h00};
    sb.push_back(e);
    dec_ready = 1'b1;
    drain("straight", 20);
    check("straight_spacing", last_acc - prev_acc, 2);

    // Field table, issued back to back from address 0
    tbl[0] = '{35'h2_1568_3C77, 4'h4, 3'd1, 2'd1, 8'h5A, 2'd0, 8'h3C, 8'h77};
    tbl[1] = '{35'h0,           4'h0, 3'd0, 2'd0, 8'h00, 2'd0, 8'h00, 8'h00};
    tbl[2] = '{35'h7_FFFF_FFFF, 4'hF, 3'd7, 2'd3, 8'hFF, 2'd3, 8'hFF, 8'hFF};
    tbl[3] = '{mk(OP_MOV, ALU_ADD, T_REG, 8'h12, T_REG, 8'h34, 8'hAB),
               4'h1, 3'd1, 2'd0, 8'h12, 2'd0, 8'h34, 8'hAB};
    tbl[4] = '{mk(4'h8, 3'd5, 2'd2, 8'h81, 2'd1, 8'h7E, 8'h00),
               4'h8, 3'd5, 2'd2, 8'h81, 2'd1, 8'h7E, 8'h00};
    tbl[5] = '{35'h0_0000_0001, 4'h0, 3'd0, 2'd0, 8'h00, 2'd0, 8'h00, 8'h01};
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = tbl[i].word;
    do_reset();
    base = acc_count;
    for (int i = 0; i < 6; i++) begin
      e = {8'(i), tbl[i].opc, tbl[i].sub, tbl[i].st, tbl[i].src, tbl[i].dt, tbl[i].dst, tbl[i].adr};
      sb.push_back(e);
    end
    dec_ready = 1'b1;
    drain("table", 40);
    check("table_accept_count", acc_count - base, 6);

    // Backpressure: fields and PC hold while ready is low
    clear_rom();
    rom[0] = mk(OP_ACC, ALU_SUB, T_REG, 8'h11, T_REG, 8'h22, 8'h33);
    do_reset();
    wait_valid("bp_valid", 5);
    e = {8'd0, OP_ACC, ALU_SUB, T_REG, 8'h11, T_REG, 8'h22, 8'h33};
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_ctl", {dec_valid, rom_addr}, {1'b1, 8'h00});
      check("bp_hold_fields", dut_fields(), e);
      tick();
    end
    base = acc_count;
    push_exp(8'd0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("bp_pc_after_accept", rom_addr, 8'd1);
    for (int i = 0; i < 4; i++) tick();
    check("bp_single_accept", acc_count - base, 1);

    // Unconditional jump from address 3 back to 1, no WAIT_BR visit
    clear_rom();
    rom[0] = mk(OP_MOV, ALU_PASS, T_NUM, 8'h01, T_REG, 8'h02, 8'h00);
    rom[1] = mk(OP_ACC, ALU_ADD, T_NUM, 8'h05, T_REG, 8'h03, 8'h00);
    rom[2] = mk(OP_MOV, ALU_PASS, T_REG, 8'h03, T_REG, REG_GOUT, 8'h00);
    rom[3] = mk(OP_JMP, COND_UNC, T_REG, 8'h00, T_REG, 8'h00, 8'd1);
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(8'(i));
    dec_ready = 1'b1;
    drain("jmp_seq", 20);
    check("jmp_target_addr", {dec_valid, rom_addr}, {1'b0, 8'd1});
    push_exp(8'd1);
    dec_ready = 1'b1;
    drain("jmp_refetch", 6);
    check("jmp_no_wait_br", last_acc - prev_acc, 2);

    // Reset in the middle of ISSUE (instruction at address 2 pending)
    wait_valid("mid_issue_valid", 5);
    check("mid_issue_pc", dec_pc, 8'd2);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl", {rom_addr, dec_valid}, 9'h0);
    check("async_reset_fields", dut_fields(), 43'h0);
    tick();
    rst_n = 1'b1;
    check("post_reset_c1_valid", dec_valid, 1'b0);
    push_exp(8'd0);
    dec_ready = 1'b1;
    tick();
    check("post_reset_c2_valid", dec_valid, 1'b1);
    drain("post_reset", 6);

    // Conditional branch taken: jmp 5 ; atc(3,10) at 5
    clear_rom();
    rom[0]  = mk(OP_JMP, COND_UNC, T_REG, 8'h00, T_REG, 8'h00, 8'd5);
    rom[5]  = mk(OP_ATC, 3'd3, T_REG, REG_FLAG, T_REG, 8'h00, 8'd10);
    rom[6]  = mk(OP_MOV, ALU_PASS, T_NUM, 8'h66, T_REG, REG_GOUT, 8'h00);
    rom[10] = mk(OP_MOV, ALU_PASS, T_NUM, 8'hA5, T_REG, REG_GOUT, 8'h00);
    do_reset();
    push_exp(8'd0);
    push_exp(8'd5);
    dec_ready = 1'b1;
    drain("atc_seq", 20);
    for (int i = 0; i < 3; i++) begin
      check("wait_br_hold", {dec_valid, rom_addr}, {1'b0, 8'd5});
      tick();
    end
    push_exp(8'd10);
    dec_ready = 1'b1;
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    tick();
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    check("br_taken_addr", rom_addr, 8'd10);
    drain("br_taken", 6);

    // br_valid during ISSUE is ignored, then branch not taken
    do_reset();
    wait_valid("ign_valid", 5);
    br_valid = 1'b1;
    br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    br_taken = 1'b0;
    check("br_ignored_in_issue", {dec_valid, rom_addr, dec_pc}, {1'b1, 8'd0, 8'd0});
    push_exp(8'd0);
    push_exp(8'd5);
    dec_ready = 1'b1;
    drain("atc_seq2", 20);
    push_exp(8'd6);
    dec_ready = 1'b1;
    br_valid  = 1'b1;
    br_taken  = 1'b0;
    tick();
    br_valid  = 1'b0;
    check("br_not_taken_addr", rom_addr, 8'd6);
    drain("br_not_taken", 6);

    // Wrap-around: zero word at 255 is issued, next fetch is address 0
    clear_rom();
    rom[0] = mk(OP_JMP, COND_UNC, T_REG, 8'h00, T_REG, 8'h00, 8'd255);
    do_reset();
    push_exp(8'd0);
    e = {8'd255, 35'h0};
    sb.push_back(e);
    push_exp(8'd0);
    dec_ready = 1'b1;
    drain("wrap", 20);
    check("wrap_rejump_addr", rom_addr, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
